// File: rtl/rtc_irq_ctrl.sv
// rtc_irq_ctrl: IIgs interrupt controller for RTC one-second/quarter-second and VGC scanline sources
// Soft-switches: C023 VGCINT, C032 clear VGC, C041 INTEN, C046 DIAG (read only), C047 clear Mega II.
// Ports:
//   CLK_14M, reset_n         system clock, asynchronous active-low reset
//   cen, sel, strobe         bus qualifiers; an access is sel & strobe & cen
//   addr, rw, din            C0xx low address byte, 1=read/0=write, write data
//   dout, rd_hit             registered read data, one-CLK pulse on a mapped read
//   onesec_in, qtrsec_in     RTC interrupt sources (edge-sensitive)
//   scan_in                  video scanline interrupt (edge-sensitive)
//   vbl_in                   vertical blank interrupt, present only with RTC_IRQ_VBL_EN
//   irq_n                    registered active-low CPU IRQ
// Define RTC_IRQ_VBL_EN to add the vbl_in source; without it vbl_st is tied to 0.
module rtc_irq_ctrl #(
    parameter logic [7:0] VGCINT_ADDR = 8'h23,
    parameter logic [7:0] CLRVGC_ADDR = 8'h32,
    parameter logic [7:0] INTEN_ADDR  = 8'h41,
    parameter logic [7:0] DIAG_ADDR   = 8'h46,
    parameter logic [7:0] CLRMII_ADDR = 8'h47
) (
    input  logic       CLK_14M,
    input  logic       reset_n,
    input  logic       cen,
    input  logic       sel,
    input  logic [7:0] addr,
    input  logic       rw,
    input  logic       strobe,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       rd_hit,
    input  logic       onesec_in,
    input  logic       qtrsec_in,
    input  logic       scan_in,
`ifdef RTC_IRQ_VBL_EN
    input  logic       vbl_in,
`endif
    output logic       irq_n
);
    logic       onesec_prev, qtr_prev, scan_prev;
    logic       sec_st, scan_st, qtr_st, vbl_st;
    logic       sec_en, scan_en;
    logic [4:0] inten;
    logic       acc, wr, rd, rd_map;
    logic       clr_sec, clr_scan, clr_mii;
    logic       irq_vgc, irq;
    logic [7:0] rd_data;
    logic       unused_din;

    assign unused_din = din[7];

    always_comb begin
        acc      = sel & strobe & cen;
        wr       = acc & ~rw;
        rd       = acc & rw;
        clr_sec  = wr & (addr == CLRVGC_ADDR) & ~din[6];
        clr_scan = wr & (addr == CLRVGC_ADDR) & ~din[5];
        clr_mii  = wr & (addr == CLRMII_ADDR);
        irq_vgc  = (sec_st & sec_en) | (scan_st & scan_en);
        irq      = irq_vgc | (qtr_st & inten[4]) | (vbl_st & inten[3]);
        rd_map   = (addr == VGCINT_ADDR) | (addr == CLRVGC_ADDR) |
                   (addr == INTEN_ADDR)  | (addr == DIAG_ADDR);
        rd_data  = (addr == VGCINT_ADDR) ? {irq_vgc, sec_st, scan_st, 2'b00, sec_en, scan_en, 1'b0} :
                   (addr == INTEN_ADDR)  ? {3'b000, inten} :
                   (addr == DIAG_ADDR)   ? {3'b000, qtr_st, vbl_st, 3'b000} : 8'h00;
    end

    // Status terms OR the rise after the clear so a same-cycle clear cannot drop an event.
    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            onesec_prev <= 1'b0;
            qtr_prev    <= 1'b0;
            scan_prev   <= 1'b0;
            sec_st      <= 1'b0;
            scan_st     <= 1'b0;
            qtr_st      <= 1'b0;
            sec_en      <= 1'b0;
            scan_en     <= 1'b0;
            inten       <= 5'd0;
            dout        <= 8'h00;
            rd_hit      <= 1'b0;
            irq_n       <= 1'b1;
        end else begin
            onesec_prev <= onesec_in;
            qtr_prev    <= qtrsec_in;
            scan_prev   <= scan_in;
            sec_st      <= (onesec_in & ~onesec_prev) | (sec_st & ~clr_sec);
            scan_st     <= (scan_in & ~scan_prev) | (scan_st & ~clr_scan);
            qtr_st      <= (qtrsec_in & ~qtr_prev) | (qtr_st & ~clr_mii);
            if (wr && addr == VGCINT_ADDR)
                {sec_en, scan_en} <= din[2:1];
            if (wr && addr == INTEN_ADDR)
                inten <= din[4:0];
            rd_hit <= rd & rd_map;
            if (rd && rd_map)
                dout <= rd_data;
            irq_n <= ~irq;
        end
    end

`ifdef RTC_IRQ_VBL_EN
    logic vbl_prev;

    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            vbl_prev <= 1'b0;
            vbl_st   <= 1'b0;
        end else begin
            vbl_prev <= vbl_in;
            vbl_st   <= (vbl_in & ~vbl_prev) | (vbl_st & ~clr_mii);
        end
    end
`else
    assign vbl_st = 1'b0;
`endif
endmodule
